multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM that sequences the RV32I multi-cycle datapath through FETCH, DECODE, EXEC, MEM and WB.
- Classifies each instruction from the instruction-decoder outputs and drives all datapath selects, the register-file write, PC update and the single shared memory port. Instruction fetch and data access both use that port.
- Traps on illegal encodings and on memory timeouts.
- Counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_ready before a trap; valid range 1..255.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; allows a new instruction to start
- opcode  input  7  decoder opcode field
- funct3  input  3  decoder funct3 field
- is_branch, is_load, is_store, is_alu_op  input  1 each  decoder class flags
- branch_taken  input  1  comparator result, valid in EXEC
- mem_ready  input  1  memory completes the current request
- mem_req  output  1  memory request
- mem_we  output  1  write enable, meaningful only with mem_req
- mem_addr_sel  output  1  memory address source: 0 = PC, 1 = alu_out register
- ir_write  output  1  latch instruction register
- alu_a_sel  output  1  ALU operand A: 0 = rs1, 1 = PC
- alu_b_sel  output  1  ALU operand B: 0 = rs2, 1 = imm
- rf_we  output  1  register-file write enable
- wb_sel  output  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm
- pc_write  output  1  PC update strobe
- pc_src  output  1  next PC: 0 = PC+4, 1 = alu_out
- retire  output  1  one-cycle pulse when an instruction completes
- instret  output  CNT_W  retired-instruction count
- trap  output  1  sticky trap flag
- trap_cause  output  2  0 = none, 1 = illegal, 2 = memory timeout
- state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
Reset and output style
- rst_n low: state=IDLE; instret=0, trap=0, trap_cause=0, wait counter=0.
- All control outputs are combinational from the state register and latched class, and are 0 in IDLE, so every output is 0 during reset. Reset mid-operation drops mem_req immediately; no cycle completes.

IDLE
- All controls 0. Go to FETCH when run=1.

FETCH
- mem_req=1, mem_we=0, mem_addr_sel=0.
- Cycle mem_ready=1: ir_write=1, go to DECODE, wait counter cleared.

DECODE (exactly 1 cycle)
- Latch class: R/I-ALU (is_alu_op), LOAD, STORE, BRANCH, LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111 with funct3=000).
- Illegal, go to TRAP with cause 1: any other opcode, JALR with funct3≠000, or branch with funct3 010/011.

EXEC (1 cycle); datapath latches alu_out at end of cycle
- R: a=0, b=0.
- I-ALU/LOAD/STORE/JALR: a=0, b=1.
- AUIPC/JAL/BRANCH: a=1, b=1.
- LUI: don't-care.
- BRANCH: pc_write=1, pc_src=branch_taken, retire=1, then go to FETCH (or IDLE if run=0).
- LOAD/STORE: go to MEM.
- All others: go to WB.

MEM
- mem_req=1, mem_addr_sel=1, mem_we=STORE.
- On mem_ready, LOAD: go to WB.
- On mem_ready, STORE: pc_write=1, pc_src=0, retire=1, then go to FETCH/IDLE.

WB (1 cycle)
- rf_we=1. wb_sel: ALU for R/I/AUIPC, memory for LOAD, PC+4 for JAL/JALR, imm for LUI.
- pc_write=1; pc_src=1 for JAL/JALR, else 0.
- retire=1, then go to FETCH/IDLE.

Instruction boundary
- Next state after retire is FETCH if run=1, else IDLE. Dropping run mid-instruction never aborts that instruction.

instret
- Increments by 1 in every retire cycle and wraps at 2^CNT_W.

Memory timeout
- Wait counter increments each FETCH/MEM cycle with mem_ready=0.
- When it reaches MEM_TIMEOUT, go to TRAP with cause 2.
- mem_ready in the same cycle as the limit wins: no trap.

TRAP
- All controls 0, trap=1, trap_cause held. Exit only via rst_n.

Protocol rules
- mem_ready is ignored while mem_req=0.
- rf_we is asserted even for rd=x0; the register file discards it.

Test Plan:
- ADD (0x00208033), run=1, mem_ready on first request cycle → state 1,2,3,5,1; rf_we=1 with wb_sel=0 in the WB cycle; instret=1 after 4 cycles.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM → 11 cycles per instruction; MEM cycle has mem_addr_sel=1, mem_we=0; WB cycle has wb_sel=1. SW → retire occurs in MEM with mem_we=1; rf_we never asserted.
- BEQ with branch_taken=1, then with 0 → EXEC cycle shows pc_write=1 with pc_src=1 then 0; 3 cycles each; no WB.
- JAL → WB cycle has wb_sel=2, pc_src=1, pc_write=1. Opcode 0x7F → DECODE goes to TRAP, trap_cause=1; run toggling has no effect until rst_n.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 → TRAP, cause 2. Repeat with mem_ready=1 in the limit cycle → no trap.
- rst_n pulsed low mid-MEM → mem_req=0 immediately; instret=0, state=0. run=0 during EXEC → instruction retires, then IDLE.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Shared memory port between the multi-cycle controller and the memory system.
// Instruction fetch and data access both go through this one request/ready pair.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the RV32I multi-cycle datapath (FETCH/DECODE/EXEC/MEM/WB),
// with illegal-instruction and memory-timeout traps and a retired-instruction counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    is_branch,
    input  logic                    is_load,
    input  logic                    is_store,
    input  logic                    is_alu_op,
    input  logic                    branch_taken,
    multicycle_controller_if.master mem,
    output logic                    ir_write,
    output logic                    alu_a_sel,
    output logic                    alu_b_sel,
    output logic                    rf_we,
    output logic [1:0]              wb_sel,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    retire,
    output logic [CNT_W-1:0]        instret,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
    } class_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // The trap fires in the MEM_TIMEOUT-th consecutive stalled cycle, so mem_req
    // is high at most MEM_TIMEOUT cycles without mem_ready; ready in that cycle wins.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    class_t     cls_q, dec_cls;
    logic       dec_ok;
    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    logic       req, we, addr_sel;
    logic       mem_limit;
    state_t     boundary;

    assign mem.mem_req      = req;
    assign mem.mem_we       = we;
    assign mem.mem_addr_sel = addr_sel;

    assign mem_limit  = (wait_q == WAIT_LIMIT);
    assign boundary   = run ? S_FETCH : S_IDLE;
    assign state      = state_q;
    assign trap_cause = cause_q;
    assign trap       = (cause_q != 2'd0);

    // Opcode-identified classes take priority over the decoder's class flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        dec_cls = C_R;
        dec_ok  = 1'b1;
        if (opcode == OP_LUI) begin
            dec_cls = C_LUI;
        end else if (opcode == OP_AUIPC) begin
            dec_cls = C_AUIPC;
        end else if (opcode == OP_JAL) begin
            dec_cls = C_JAL;
        end else if (opcode == OP_JALR) begin
            dec_cls = C_JALR;
            dec_ok  = (funct3 == 3'b000);
        end else if (is_load) begin
            dec_cls = C_LOAD;
        end else if (is_store) begin
            dec_cls = C_STORE;
        end else if (is_branch) begin
            dec_cls = C_BRANCH;
            dec_ok  = (funct3 != 3'b010) && (funct3 != 3'b011);
        end else if (is_alu_op) begin
            dec_cls = (opcode == OP_R) ? C_R : C_I;
        end else begin
            dec_ok = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cause_d   = cause_q;
        req       = 1'b0;
        we        = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    wait_d   = 8'd0;
                    state_d  = S_DECODE;
                end else if (mem_limit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                wait_d = 8'd0;
                if (dec_ok) begin
                    state_d = S_EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_I, C_LOAD, C_STORE, C_JALR: alu_b_sel = 1'b1;
                    C_AUIPC, C_JAL, C_BRANCH: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase
                if (cls_q == C_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                    retire   = 1'b1;
                    state_d  = boundary;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = (cls_q == C_STORE);
                if (mem.mem_ready) begin
                    wait_d = 8'd0;
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = boundary;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (mem_limit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = boundary;
                case (cls_q)
                    C_LOAD: wb_sel = WB_MEM;
                    C_JAL, C_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = 1'b1;
                    end
                    C_LUI:  wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end
            S_TRAP: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_R;
            wait_q  <= 8'd0;
            cause_q <= 2'd0;
            instret <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases, randomized instruction
// stream against a per-instruction phase model, traps, and asynchronous reset.
module tb_multicycle_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    typedef enum int {K_ADD, K_ADDI, K_LW, K_SW, K_BEQ, K_LUI, K_AUIPC, K_JAL, K_JALR} kind_t;

    logic clk = 1'b0;
    logic rst_n, run, is_branch, is_load, is_store, is_alu_op, branch_taken;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic ir_write, alu_a_sel, alu_b_sel, rf_we, pc_write, pc_src, retire, trap;
    logic [1:0] wb_sel, trap_cause;
    logic [2:0] state;
    logic [CNT_W-1:0] instret;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] model_instret;

    multicycle_controller_if mif ();

    multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
        .is_alu_op(is_alu_op), .branch_taken(branch_taken), .mem(mif),
        .ir_write(ir_write), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] all_controls();
        return {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, alu_a_sel,
                alu_b_sel, rf_we, wb_sel, pc_write, pc_src};
    endfunction

    task automatic set_instr(input kind_t k);
        int f;
        is_branch = 1'b0; is_load = 1'b0; is_store = 1'b0; is_alu_op = 1'b0;
        funct3 = 3'b000;
        case (k)
            K_ADD:   begin opcode = 7'b0110011; is_alu_op = 1'b1; end
            K_ADDI:  begin opcode = 7'b0010011; is_alu_op = 1'b1; funct3 = 3'($urandom_range(0, 7)); end
            K_LW:    begin opcode = 7'b0000011; is_load = 1'b1; funct3 = 3'b010; end
            K_SW:    begin opcode = 7'b0100011; is_store = 1'b1; funct3 = 3'b010; end
            K_BEQ: begin
                opcode = 7'b1100011; is_branch = 1'b1;
                f = int'($urandom_range(0, 5));
                funct3 = (f < 2) ? 3'(f) : 3'(f + 2);
            end
            K_LUI:   opcode = 7'b0110111;
            K_AUIPC: opcode = 7'b0010111;
            K_JAL:   opcode = 7'b1101111;
            default: opcode = 7'b1100111;
        endcase
    endtask

    // {alu_a_sel, alu_b_sel} expected in EXEC.
    function automatic logic [1:0] exp_ab(input kind_t k);
        case (k)
            K_ADD:                       return 2'b00;
            K_ADDI, K_LW, K_SW, K_JALR:  return 2'b01;
            default:                     return 2'b11;
        endcase
    endfunction

    // {retire, pc_write, pc_src, rf_we, wb_sel} expected in the completing cycle.
    function automatic logic [5:0] exp_final(input kind_t k, input logic bt);
        case (k)
            K_BEQ:        return {1'b1, 1'b1, bt,   1'b0, 2'd0};
            K_SW:         return {1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
            K_LW:         return {1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
            K_JAL, K_JALR: return {1'b1, 1'b1, 1'b1, 1'b1, 2'd2};
            K_LUI:        return {1'b1, 1'b1, 1'b0, 1'b1, 2'd3};
            default:      return {1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
        endcase
    endfunction

    // Runs one instruction starting in FETCH. fd/md are stall cycles before mem_ready.
    task automatic run_instr(input kind_t k, input int fd, input int md,
                             input logic bt, input logic run_after);
        int phase[$];
        int fetch_i = 0;
        int mem_i = 0;
        logic exp_ready;
        for (int i = 0; i <= fd; i++) phase.push_back(1);
        phase.push_back(2);
        phase.push_back(3);
        if (k == K_LW || k == K_SW) for (int i = 0; i <= md; i++) phase.push_back(4);
        if (k != K_SW && k != K_BEQ) phase.push_back(5);
        set_instr(k);
        branch_taken = bt;
        for (int c = 0; c < phase.size(); c++) begin
            if (phase[c] == 1)      exp_ready = (fetch_i == fd);
            else if (phase[c] == 4) exp_ready = (mem_i == md);
            else                    exp_ready = 1'($urandom);
            mif.mem_ready = exp_ready;
            run = (c > fd) ? run_after : 1'b1;
            @(negedge clk);
            check("state", 32'(state), 32'(phase[c]));
            if (phase[c] == 1) begin
                check("fetch_port", {mif.mem_req, mif.mem_addr_sel, mif.mem_we}, 3'b100);
                check("ir_write", ir_write, exp_ready);
                fetch_i++;
            end
            if (phase[c] == 2) check("decode_no_req", mif.mem_req, 1'b0);
            if (phase[c] == 3 && k != K_LUI) check("exec_ab", {alu_a_sel, alu_b_sel}, exp_ab(k));
            if (phase[c] == 4) begin
                check("mem_port", {mif.mem_req, mif.mem_addr_sel, mif.mem_we}, {2'b11, k == K_SW});
                mem_i++;
            end
            if (c == phase.size() - 1)
                check("final_ctl", {retire, pc_write, pc_src, rf_we, wb_sel}, exp_final(k, bt));
            else
                check("mid_ctl", {retire, pc_write, rf_we}, 3'b000);
            cyc();
        end
        model_instret = model_instret + 1'b1;
        check("instret", instret, model_instret);
        check("boundary", state, run_after ? 3'd1 : 3'd0);
        if (!run_after) begin
            int n_idle = int'($urandom_range(1, 3));
            for (int i = 0; i < n_idle; i++) begin
                run = (i == n_idle - 1);
                mif.mem_ready = 1'($urandom);
                @(negedge clk);
                check("idle_ctl", {state, all_controls()}, 14'd0);
                cyc();
            end
        end
    endtask

    task automatic reset_to_fetch();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_state", {state, trap, trap_cause, instret}, '0);
        rst_n = 1'b1;
        model_instret = '0;
        run = 1'b1;
        cyc();
    endtask

    task automatic expect_trap(input logic [1:0] cause);
        check("trap_state", {state, trap, trap_cause}, {3'd6, 1'b1, cause});
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom);
            mif.mem_ready = 1'($urandom);
            @(negedge clk);
            check("trap_hold", {state, trap_cause, all_controls(), retire}, {3'd6, cause, 11'd0, 1'b0});
            cyc();
        end
        check("trap_instret", instret, model_instret);
        reset_to_fetch();
    endtask

    task automatic illegal(input logic [6:0] opc, input logic [2:0] f3, input logic br);
        opcode = opc; funct3 = f3;
        is_branch = br; is_load = 1'b0; is_store = 1'b0; is_alu_op = 1'b0;
        mif.mem_ready = 1'b1;
        cyc();
        mif.mem_ready = 1'b0;
        @(negedge clk);
        check("ill_decode", state, 3'd2);
        cyc();
        expect_trap(2'd1);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0; funct3 = '0;
        is_branch = 1'b0; is_load = 1'b0; is_store = 1'b0; is_alu_op = 1'b0;
        branch_taken = 1'b0; mif.mem_ready = 1'b0; model_instret = '0;

        #3;
        check("reset_state", {state, trap, trap_cause, instret}, '0);
        check("reset_ctl", {all_controls(), retire}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        cyc();

        run_instr(K_ADD, 0, 0, 1'b0, 1'b1);
        run_instr(K_LW, 3, 3, 1'b0, 1'b1);
        run_instr(K_SW, 1, 2, 1'b0, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b1, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b0, 1'b1);
        run_instr(K_JAL, 0, 0, 1'b0, 1'b1);
        run_instr(K_JALR, 2, 0, 1'b0, 1'b1);
        run_instr(K_LUI, 0, 0, 1'b0, 1'b1);
        run_instr(K_AUIPC, 1, 0, 1'b0, 1'b1);
        run_instr(K_ADDI, 0, 0, 1'b0, 1'b1);
        run_instr(K_ADD, MEM_TIMEOUT - 1, 0, 1'b0, 1'b1);
        run_instr(K_LW, 0, MEM_TIMEOUT - 1, 1'b0, 1'b1);
        run_instr(K_ADD, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_instr(kind_t'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'($urandom), $urandom_range(0, 3) != 0);

        // Asynchronous reset in the middle of a MEM stall.
        set_instr(K_LW);
        mif.mem_ready = 1'b1;
        cyc();
        mif.mem_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("pre_rst_mem", {state, mif.mem_req}, {3'd4, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem", {state, mif.mem_req, instret}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_instret = '0;
        run = 1'b1;
        cyc();

        illegal(7'h7F, 3'b000, 1'b0);
        illegal(7'b1100111, 3'b001, 1'b0);
        illegal(7'b1100011, 3'b010, 1'b1);

        // Fetch stalls for MEM_TIMEOUT cycles without ready.
        set_instr(K_ADD);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            mif.mem_ready = 1'b0;
            @(negedge clk);
            check("stall_fetch", {state, mif.mem_req}, {3'd1, 1'b1});
            cyc();
        end
        expect_trap(2'd2);

        run_instr(K_ADD, 0, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
